// File: rtl/fp32_div_seq.sv
// fp32_div_seq: sequential IEEE-754 single-precision divider.
// A start in IDLE either resolves a special case in one cycle, or runs a
// 26-iteration restoring mantissa divide followed by a normalise/pack cycle.
// Subnormal inputs are flushed to zero.
// Optional feature macro: FP_DIV_ROUND_EN selects round-to-nearest-even.
// Without it the quotient mantissa is truncated. Latency is the same in both builds.
module fp32_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic        DivByZero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_result;
  logic                r_exc;
  logic                r_ovf;
  logic                r_unf;
  logic                r_dbz;
  logic                r_sign;
  logic [24:0]         r_rem;
  logic [23:0]         r_div;
  logic [25:0]         r_q;
  logic [4:0]          r_cnt;
  logic signed [9:0]   r_e;

  // Operand decode for the accept cycle.
  logic [7:0]          w_ea;
  logic [7:0]          w_eb;
  logic                w_sign;
  logic                w_a_zero;
  logic                w_b_zero;
  logic                w_exc;
  logic signed [9:0]   w_e_init;

  assign w_ea     = a_operand[30:23];
  assign w_eb     = b_operand[30:23];
  assign w_sign   = a_operand[31] ^ b_operand[31];
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_exc    = (w_ea == 8'hFF) || (w_eb == 8'hFF) || (w_a_zero && w_b_zero);
  assign w_e_init = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;

  // One restoring-divide step: compare, conditionally subtract.
  logic                w_ge;
  logic [24:0]         w_rem_sub;

  assign w_ge      = (r_rem >= {1'b0, r_div});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

  // Normalise the 26-bit quotient, optionally round, and form the final exponent.
  logic [22:0]         w_mant;
  logic [22:0]         w_mant_fin;
  logic signed [9:0]   w_e_norm;
  logic signed [9:0]   w_e_fin;
`ifdef FP_DIV_ROUND_EN
  logic                w_guard;
  logic                w_sticky;
  logic                w_carry;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_mant     = r_q[24:2];
    w_e_norm   = r_e;
`ifdef FP_DIV_ROUND_EN
    w_guard    = r_q[1];
    w_sticky   = r_q[0] | (|r_rem);
    w_carry    = 1'b0;
`endif
    if (!r_q[25]) begin
      w_mant   = r_q[23:1];
      w_e_norm = r_e - 10'sd1;
`ifdef FP_DIV_ROUND_EN
      w_guard  = r_q[0];
      w_sticky = |r_rem;
`endif
    end
    w_mant_fin = w_mant;
    w_e_fin    = w_e_norm;
`ifdef FP_DIV_ROUND_EN
    if (w_guard & (w_sticky | w_mant[0])) begin
      {w_carry, w_mant_fin} = {1'b0, w_mant} + 24'd1;
      // A carry out wraps the mantissa to zero and bumps the exponent.
      if (w_carry) w_e_fin = w_e_norm + 10'sd1;
    end
`endif
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_sign   <= 1'b0;
      r_rem    <= 25'd0;
      r_div    <= 24'd0;
      r_q      <= 26'd0;
      r_cnt    <= 5'd0;
      r_e      <= 10'sd0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign <= w_sign;
            if (w_exc) begin
              r_result <= {w_sign, 8'hFF, 23'd0};
              {r_exc, r_ovf, r_unf, r_dbz} <= 4'b1000;
              r_done   <= 1'b1;
            end else if (w_b_zero) begin
              r_result <= {w_sign, 8'hFF, 23'd0};
              {r_exc, r_ovf, r_unf, r_dbz} <= 4'b0001;
              r_done   <= 1'b1;
            end else if (w_a_zero) begin
              r_result <= {w_sign, 31'd0};
              {r_exc, r_ovf, r_unf, r_dbz} <= 4'b0000;
              r_done   <= 1'b1;
            end else begin
              r_rem   <= {2'b01, a_operand[22:0]};
              r_div   <= {1'b1, b_operand[22:0]};
              r_q     <= 26'd0;
              r_cnt   <= 5'd0;
              r_e     <= w_e_init;
              r_busy  <= 1'b1;
              r_state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= w_rem_sub << 1;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd25) r_state <= NORM;
        end
        NORM: begin
          if (w_e_fin >= 10'sd255) begin
            r_result <= {r_sign, 8'hFF, 23'd0};
            {r_exc, r_ovf, r_unf, r_dbz} <= 4'b0100;
          end else if (w_e_fin <= 10'sd0) begin
            r_result <= {r_sign, 31'd0};
            {r_exc, r_ovf, r_unf, r_dbz} <= 4'b0010;
          end else begin
            r_result <= {r_sign, w_e_fin[7:0], w_mant_fin};
            {r_exc, r_ovf, r_unf, r_dbz} <= 4'b0000;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign Exception = r_exc;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;
  assign DivByZero = r_dbz;

endmodule

// File: tb/tb_fp32_div_seq.sv
// tb_fp32_div_seq: directed self-checking bench for fp32_div_seq.
// Flags are compared as a 4-bit vector {Exception, Overflow, Underflow, DivByZero}.
// Latency is counted in clock edges after the accepting edge (0 for special cases).
module tb_fp32_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        Exception;
  logic        Overflow;
  logic        Underflow;
  logic        DivByZero;

  int checks = 0;
  int errors = 0;

  fp32_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .DivByZero (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, Exception, Overflow, Underflow, DivByZero};
  endfunction

  // Issue one operation and wait (bounded) for done; samples 1 time unit after edges.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     output int lat, output logic busy_acc);
    @(negedge clk);
    start     = 1'b1;
    a_operand = a;
    b_operand = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_acc = busy;
    lat      = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int          lat;
  logic        bacc;
  int          done_seen;
  logic [31:0] exp_third;

  initial begin
`ifdef FP_DIV_ROUND_EN
    exp_third = 32'h3EAAAAAB;
`else
    exp_third = 32'h3EAAAAAA;
`endif
    rst_n     = 1'b0;
    start     = 1'b0;
    a_operand = 32'd0;
    b_operand = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_ctrl", {30'd0, busy, done}, 32'd0);
    check("reset_flags", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6.0 / 2.0 with latency, busy and single-cycle done.
    run(32'h40C00000, 32'h40000000, lat, bacc);
    check("div6_2_latency", lat, 27);
    check("div6_2_busy_at_accept", {31'd0, bacc}, 32'd1);
    check("div6_2_result", result, 32'h40400000);
    check("div6_2_flags", flags(), 32'd0);
    check("div6_2_busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("div6_2_done_one_cycle", {31'd0, done}, 32'd0);

    // 1.0 / 3.0: rounding-sensitive.
    run(32'h3F800000, 32'h40400000, lat, bacc);
    check("div1_3_result", result, exp_third);
    check("div1_3_flags", flags(), 32'd0);

    // Divide by zero, single-cycle special case.
    run(32'h3F800000, 32'h00000000, lat, bacc);
    check("dbz_latency", lat, 0);
    check("dbz_busy", {31'd0, bacc}, 32'd0);
    check("dbz_result", result, 32'h7F800000);
    check("dbz_flags", flags(), 32'h1);

    // 0 / 0 is an exception.
    run(32'h00000000, 32'h00000000, lat, bacc);
    check("zero_zero_result", result, 32'h7F800000);
    check("zero_zero_flags", flags(), 32'h8);

    // Zero dividend over negative divisor gives signed zero.
    run(32'h00000000, 32'hC0000000, lat, bacc);
    check("zero_div_result", result, 32'h80000000);
    check("zero_div_flags", flags(), 32'h0);

    // Overflow and underflow.
    run(32'h7F000000, 32'h00800000, lat, bacc);
    check("ovf_result", result, 32'h7F800000);
    check("ovf_flags", flags(), 32'h4);
    run(32'h00800000, 32'h7F000000, lat, bacc);
    check("unf_result", result, 32'h00000000);
    check("unf_flags", flags(), 32'h2);

    // Sign handling and infinity input.
    run(32'hC0C00000, 32'h40000000, lat, bacc);
    check("neg_result", result, 32'hC0400000);
    check("neg_flags", flags(), 32'h0);
    run(32'h7F800000, 32'h3F800000, lat, bacc);
    check("inf_result", result, 32'h7F800000);
    check("inf_flags", flags(), 32'h8);

    // Start pulsed at cycle 5 of a division must be ignored.
    @(negedge clk);
    start     = 1'b1;
    a_operand = 32'h40C00000;
    b_operand = 32'h40000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start     = 1'b1;
    a_operand = 32'h3F800000;
    b_operand = 32'h00000000;
    @(posedge clk);
    #1;
    start     = 1'b0;
    a_operand = 32'h0;
    b_operand = 32'h0;
    lat = 5;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore_start_latency", lat, 27);
    check("ignore_start_result", result, 32'h40400000);
    check("ignore_start_flags", flags(), 32'h0);

    // Back-to-back: new start issued in the done cycle.
    start     = 1'b1;
    a_operand = 32'h3F800000;
    b_operand = 32'h3F800000;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_latency", lat, 27);
    check("b2b_result", result, 32'h3F800000);

    // Reset at cycle 10 of a division clears outputs and suppresses done.
    run(32'h7F800000, 32'h3F800000, lat, bacc);
    @(negedge clk);
    start     = 1'b1;
    a_operand = 32'h40C00000;
    b_operand = 32'h40000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_ctrl", {30'd0, busy, done}, 32'd0);
    check("abort_flags", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
